gram_skew_feeder: RTL and testbench
===================================

// Module: gram_skew_feeder
// PURPOSE
//   Upstream feeder for the Gram-matrix systolic array of PE_gram cells. Holds one DIMENSION x DIMENSION
//   input matrix X written via a simple write port. On start it streams X into the array with
//   diagonal skew: lane i carries column i of X, delayed i cycles. Lane i drives in_A/in_B/en of
//   the array edge PEs. Each lane presents exactly DIMENSION contiguous enabled cycles, matching the
//   PE's per-row accumulation count.
// PARAMETERS
//   WIDTH      8  element width, bits (same as PE_gram WIDTH)
//   DIMENSION  4  matrix order D, number of lanes; 2..16
//   AW         $clog2(DIMENSION)  (localparam) row/col address width
// PORTS
//   clk      in   1            rising-edge clock
//   rst      in   1            asynchronous reset, active-low
//   wr_en    in   1            write one element of X
//   wr_row   in   AW           row index k of written element
//   wr_col   in   AW           column index i of written element
//   wr_data  in   WIDTH        element value X[k][i]
//   wr_err   out  1            one-cycle pulse: write rejected (busy or index out of range)
//   start    in   1            begin streaming (sampled only in IDLE)
//   busy     out  1            high while in STREAM
//   done     out  1            one-cycle pulse after the last skewed beat
//   a_out    out  D*WIDTH      lane i at [i*WIDTH +: WIDTH]; A operand to array row i
//   b_out    out  D*WIDTH      lane j at [j*WIDTH +: WIDTH]; B operand to array column j
//   en_out   out  D            per-lane enable to the array edge
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, t=0, storage X cleared to 0.
//     a_out=0, b_out=0, en_out=0, busy=0, done=0, wr_err=0. Takes effect immediately.
//   - FSM IDLE -> STREAM -> DONE -> IDLE. All outputs are registered.
//     IDLE:   start=1 -> STREAM with t=0. start=0 -> stay.
//     STREAM: t increments each cycle. At t=2D-2 the next state is DONE.
//     DONE:   done=1 for one cycle, then IDLE. start is not sampled in DONE.
//   - Skew rule, for the cycle in STREAM at step t, for each lane i:
//       if i <= t <= i+D-1: en_out[i]=1; a_out lane i = X[t-i][i]; b_out lane i = X[t-i][i].
//       otherwise: en_out[i]=0 and both lane i data fields = 0.
//     Outside STREAM: all en_out=0 and all data fields=0.
//   - Latency: start high at edge c (in IDLE) -> first STREAM cycle is c+1 with en_out=...0001 and lane0=X[0][0].
//     The stream lasts 2D-1 cycles. done is high in cycle c+2D.
//   - busy = (state==STREAM). busy=0 in DONE.
//   - Writes:
//     accepted only when state is IDLE or DONE and wr_row<D and wr_col<D; X[wr_row][wr_col]<=wr_data at the clock edge.
//     Otherwise the write is dropped and wr_err=1 in the next cycle.
//     A write and a start in the same IDLE cycle: the write lands first, so the new value is streamed.
//   - X is read-only during STREAM. Contents persist across streams. Re-start without rewrite replays the same X.
//   - start during STREAM or DONE is ignored (not queued).
//   - Reset mid-STREAM: all en_out drop to 0 immediately and X is cleared. No done pulse.
//   - Arithmetic: t counter is $clog2(2D-1)+1 bits wide and has no wrap. Index t-i is computed only inside the valid window.
// TESTING
//   - D=4, W=8: write X[k][i]=16*k+i, pulse start. Check en_out per cycle: 0001,0011,0111,1111,1110,1100,1000.
//     Check lane2 data at t=2..5: 0x02,0x12,0x22,0x32. done pulses at c+8.
//   - Pulse start again at t=3 of a stream: no effect. done fires once.
//     A second start in IDLE replays identical values.
//   - Write during STREAM (row1,col1,0xFF): wr_err pulses. The next stream still shows X[1][1]=0x11.
//     Write in IDLE with wr_row=4 when D=5 and wr_row=5: the second write gets wr_err.
//   - Assert rst=0 at t=4 without a clock edge: outputs are 0 at once. After release, start streams all zeros and en windows are intact.
//   - Same-cycle write X[0][0]=0xAA plus start: first beat lane0=0xAA.
//   - D=2 build: en_out sequence 01,11,10. done at c+4. Connect to PE_gram instances and check G=X^T X, modulo 2^WIDTH.

Source files
------------

// File: rtl/gram_skew_feeder.sv
// Holds a DIMENSION x DIMENSION matrix and streams it into the Gram systolic array with diagonal
// skew: lane i carries column i, delayed i cycles, for DIMENSION enabled beats.
module gram_skew_feeder #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIMENSION = 4,
    localparam int unsigned AW       = $clog2(DIMENSION)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_row,
    input  logic [AW-1:0]              wr_col,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_err,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [DIMENSION*WIDTH-1:0] a_out,
    output logic [DIMENSION*WIDTH-1:0] b_out,
    output logic [DIMENSION-1:0]       en_out
);
    localparam int unsigned TW = $clog2(2 * DIMENSION - 1) + 1;

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e                     r_state, w_state_d;
    logic [TW-1:0]              r_t, w_t_d;
    logic [WIDTH-1:0]           r_x [DIMENSION][DIMENSION];
    logic [DIMENSION*WIDTH-1:0] r_a, w_a_d;
    logic [DIMENSION-1:0]       r_en, w_en_d;
    logic                       r_busy, r_done, r_wr_err;
    logic                       w_wr_ok;
    logic [AW-1:0]              w_row;
    int                         w_k;

    always_comb begin
        w_state_d = r_state;
        w_t_d     = r_t;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StStream;
                    w_t_d     = '0;
                end
            end
            StStream: begin
                if (r_t == TW'(2 * DIMENSION - 2)) begin
                    w_state_d = StDone;
                    w_t_d     = '0;
                end else begin
                    w_t_d = r_t + TW'(1);
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    assign w_wr_ok = wr_en && (r_state != StStream) &&
                     (32'(wr_row) < DIMENSION) && (32'(wr_col) < DIMENSION);

    // Lane data is built from next-state values so every output leaves a register; a write
    // accepted on the start edge is forwarded so the fresh value is what gets streamed.
    always_comb begin
        w_en_d = '0;
        w_a_d  = '0;
        w_k    = 0;
        w_row  = '0;
        for (int i = 0; i < int'(DIMENSION); i++) begin
            w_k = int'(32'(w_t_d)) - i;
            if (w_state_d == StStream && w_k >= 0 && w_k < int'(DIMENSION)) begin
                w_en_d[i] = 1'b1;
                w_row     = w_k[AW-1:0];
                if (w_wr_ok && wr_row == w_row && wr_col == AW'(i)) begin
                    w_a_d[i*WIDTH +: WIDTH] = wr_data;
                end else begin
                    w_a_d[i*WIDTH +: WIDTH] = r_x[w_row][i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_t      <= '0;
            r_a      <= '0;
            r_en     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_err <= 1'b0;
            for (int r = 0; r < int'(DIMENSION); r++) begin
                for (int c = 0; c < int'(DIMENSION); c++) begin
                    r_x[r][c] <= '0;
                end
            end
        end else begin
            r_state  <= w_state_d;
            r_t      <= w_t_d;
            r_a      <= w_a_d;
            r_en     <= w_en_d;
            r_busy   <= (w_state_d == StStream);
            r_done   <= (w_state_d == StDone);
            r_wr_err <= wr_en && !w_wr_ok;
            if (w_wr_ok) begin
                r_x[wr_row][wr_col] <= wr_data;
            end
        end
    end

    assign a_out  = r_a;
    assign b_out  = r_a;
    assign en_out = r_en;
    assign busy   = r_busy;
    assign done   = r_done;
    assign wr_err = r_wr_err;

endmodule

// File: tb/tb_gram_skew_feeder.sv
// Bench for gram_skew_feeder: a timeline model of the skewed stream checked every cycle, plus
// directed literal checks on D=4, D=5 (range errors) and D=2 builds.
module tb_gram_skew_feeder;
    localparam int D = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en, start;
    logic [1:0]     wr_row, wr_col;
    logic [W-1:0]   wr_data;
    logic           wr_err, busy, done;
    logic [D*W-1:0] a_out, b_out;
    logic [D-1:0]   en_out;

    logic           wr_en5, start5, wr_err5, busy5, done5;
    logic [2:0]     wr_row5, wr_col5;
    logic [7:0]     wr_data5;
    logic [39:0]    a_out5, b_out5;
    logic [4:0]     en_out5;

    logic           wr_en2, start2, wr_err2, busy2, done2;
    logic [0:0]     wr_row2, wr_col2;
    logic [7:0]     wr_data2;
    logic [15:0]    a_out2, b_out2;
    logic [1:0]     en_out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gram_skew_feeder #(.WIDTH(W), .DIMENSION(D)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .wr_err(wr_err), .start(start), .busy(busy), .done(done),
        .a_out(a_out), .b_out(b_out), .en_out(en_out)
    );

    gram_skew_feeder #(.WIDTH(8), .DIMENSION(5)) u_d5 (
        .clk(clk), .rst(rst), .wr_en(wr_en5), .wr_row(wr_row5), .wr_col(wr_col5),
        .wr_data(wr_data5), .wr_err(wr_err5), .start(start5), .busy(busy5), .done(done5),
        .a_out(a_out5), .b_out(b_out5), .en_out(en_out5)
    );

    gram_skew_feeder #(.WIDTH(8), .DIMENSION(2)) u_d2 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_row(wr_row2), .wr_col(wr_col2),
        .wr_data(wr_data2), .wr_err(wr_err2), .start(start2), .busy(busy2), .done(done2),
        .a_out(a_out2), .b_out(b_out2), .en_out(en_out2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 'since' counts edges since an accepted start (-1 when idle). Stream beats are
    // since=1..2D-1 with t=since-1, done is since=2D.
    logic [W-1:0] mx [D][D];
    int           since;
    logic         m_err;
    logic         m_streaming;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < D; r++)
                for (int c = 0; c < D; c++) mx[r][c] = '0;
            since = -1;
            m_err = 1'b0;
        end else begin
            m_streaming = (since >= 1) && (since <= 2 * D - 1);
            m_err = wr_en && m_streaming;
            if (wr_en && !m_streaming) mx[wr_row][wr_col] = wr_data;
            if (since == -1 && start) since = 0;
            if (since >= 0) since++;
            if (since > 2 * D) since = -1;
        end
    end

    always @(negedge clk) begin
        logic [D-1:0]   e_en;
        logic [D*W-1:0] e_a;
        int             t;
        logic           strm;
        e_en = '0;
        e_a  = '0;
        t    = since - 1;
        strm = (since >= 1) && (since <= 2 * D - 1);
        for (int i = 0; i < D; i++) begin
            if (strm && t >= i && t <= i + D - 1) begin
                e_en[i]       = 1'b1;
                e_a[i*W +: W] = mx[t-i][i];
            end
        end
        chk("cyc_en", 64'(en_out), 64'(e_en));
        chk("cyc_a", 64'(a_out), 64'(e_a));
        chk("cyc_b", 64'(b_out), 64'(e_a));
        chk("cyc_flags", 64'({busy, done, wr_err}), 64'({strm, since == 2 * D, m_err}));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_row  = r[1:0];
        wr_col  = c[1:0];
        wr_data = d[7:0];
        tick();
        wr_en = 1'b0;
    endtask

    logic [3:0] lit_en [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [7:0] lit_l2 [4] = '{8'h02, 8'h12, 8'h22, 8'h32};
    logic [1:0] lit_en2 [3] = '{2'b01, 2'b11, 2'b10};

    initial begin
        int ndone;
        rst = 1'b0; wr_en = 1'b0; start = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        wr_en5 = 1'b0; start5 = 1'b0; wr_row5 = '0; wr_col5 = '0; wr_data5 = '0;
        wr_en2 = 1'b0; start2 = 1'b0; wr_row2 = '0; wr_col2 = '0; wr_data2 = '0;
        #12 rst = 1'b1;
        chk("reset_en", 64'(en_out), 64'd0);
        chk("reset_flags", 64'({busy, done, wr_err}), 64'd0);

        for (int k = 0; k < D; k++)
            for (int i = 0; i < D; i++) wr(k, i, 16 * k + i);

        // Stream 1: skew windows, lane 2 data, done at c+2D
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("s1_en", 64'(en_out), 64'(lit_en[k]));
            if (k >= 2 && k <= 5) chk("s1_lane2", 64'(a_out[23:16]), 64'(lit_l2[k-2]));
            tick();
        end
        chk("s1_done", 64'({busy, done}), 64'b01);
        tick();

        // Stream 2: rejected write and ignored start mid-stream
        ndone = 0;
        start = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) begin
                wr_en = 1'b1; wr_row = 2'd1; wr_col = 2'd1; wr_data = 8'hFF;
            end
            if (k == 3) start = 1'b1;
            tick();
            wr_en = 1'b0; start = 1'b0;
            if (k == 1) chk("s2_wr_err", 64'(wr_err), 64'd1);
            ndone += int'(done);
        end
        chk("s2_done_once", 64'(ndone), 64'd1);

        // Stream 3: X[1][1] untouched by the rejected write
        start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick(); start = 1'b0;
            if (k == 2) chk("s3_x11", 64'(a_out[15:8]), 64'h11);
        end
        tick(); tick();

        // Asynchronous reset at t=4, between edges
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        #1 rst = 1'b0;
        #1 chk("arst_en", 64'(en_out), 64'd0);
        chk("arst_a", 64'(a_out), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        #10 rst = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("post_rst_en", 64'(en_out), 64'(lit_en[k]));
            chk("post_rst_a", 64'(a_out), 64'd0);
            tick();
        end
        tick();

        // Same-cycle write and start: new value streamed on the first beat
        wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'hAA; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("wrstart_lane0", 64'(a_out[7:0]), 64'hAA);
        chk("wrstart_en", 64'(en_out), 64'b0001);
        repeat (8) tick();

        // D=5: row 4 in range, row 5 rejected
        wr_en5 = 1'b1; wr_row5 = 3'd4; wr_col5 = 3'd0; wr_data5 = 8'h5A;
        tick(); wr_en5 = 1'b0;
        chk("d5_row4_ok", 64'(wr_err5), 64'd0);
        wr_en5 = 1'b1; wr_row5 = 3'd5;
        tick(); wr_en5 = 1'b0;
        chk("d5_row5_err", 64'(wr_err5), 64'd1);

        // D=2: windows 01,11,10 and done at c+4
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("d2_en", 64'(en_out2), 64'(lit_en2[k]));
            tick();
        end
        chk("d2_done", 64'({busy2, done2}), 64'b01);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
